monitor_comparador: RTL and testbench
=====================================

// Module: monitor_comparador
// PURPOSE
//   Sequential checker downstream of the 4-bit shift-register comparison stage.
//   - Samples both register models every enabled cycle: parallel Q and serial S_OUT.
//   - Counts comparisons and mismatches, and captures the first failing cycle and data.
//   - Ends the run with DONE/PASS, or latches FAIL once the error count reaches a limit.
// PARAMETERS
//   W        4   width of the parallel outputs being compared (QA/QB)
//   CW       16  width of the comparison counter, cycle counter and FIRST_CYC
//   EW       8   width of the error counter
//   MAX_ERR  4   mismatch count that forces FAIL; 1..2**EW-1
//   SKIP     1   enabled samples ignored after START; covers register fill latency
// PORTS
//   CLK        in   1   clock; all logic on the rising edge
//   RESET      in   1   synchronous, active-low reset
//   START      in   1   begin a run: clears counters and captures; enters RUN
//   STOP       in   1   end the run normally (RUN -> DONE)
//   ENB        in   1   sample qualifier; same ENB that drives the register models
//   QA         in   W   parallel output, conditional model
//   QB         in   W   parallel output, structural model
//   SA         in   1   serial output S_OUT, conditional model
//   SB         in   1   serial output S_OUT, structural model
//   Q_EQ       out  1   registered: QA==QB at the last counted sample
//   S_EQ       out  1   registered: SA==SB at the last counted sample
//   CMP_CNT    out  CW  counted comparisons this run; saturates at all-ones
//   ERR_CNT    out  EW  mismatching samples this run; one per sample, even if Q and S both differ
//   FIRST_CYC  out  CW  cycles since RUN entry at the first mismatch; 0 if none
//   FIRST_QA   out  W   QA captured at the first mismatch
//   FIRST_QB   out  W   QB captured at the first mismatch
//   STICKY     out  1   set on the first mismatch; cleared only by RESET or START
//   DONE       out  1   high in DONE and FAIL states
//   PASS       out  1   DONE & (ERR_CNT==0)
//   STATE      out  2   IDLE=0, RUN=1, DONE=2, FAIL=3
// BEHAVIOUR
//   - Reset (RESET=0 at a rising edge):
//       state IDLE; every output 0, except Q_EQ=S_EQ=1.
//       Reset mid-run discards everything.
//   - START=1 in any state: next state RUN.
//       Clears counters, captures, STICKY, the skip counter and the cycle counter.
//       Sets Q_EQ=S_EQ=1.
//       START has priority over STOP and over a mismatch in the same cycle.
//   - RUN, cycle counter: increments every cycle (ENB ignored).
//   - RUN, counted sample: a cycle with ENB=1 once SKIP enabled samples have passed.
//       Disabled cycles neither count nor compare.
//   - Mismatch: QA!==QB or SA!==SB (case inequality: X/Z counts as a mismatch).
//   - Latency: one cycle. Results for the sample at edge k are visible after edge k:
//       Q_EQ, S_EQ, CMP_CNT+1, ERR_CNT+1 (on a mismatch).
//   - First mismatch (STICKY=0): same edge sets STICKY and loads
//       FIRST_CYC = cycle counter, FIRST_QA = QA, FIRST_QB = QB.
//       Later mismatches never overwrite the captures.
//   - RUN transitions:
//       ERR_CNT reaching MAX_ERR -> FAIL (same edge as that increment).
//       Otherwise STOP=1 -> DONE.
//       STOP together with a mismatch: the sample is counted first.
//       If that sample hits MAX_ERR, the state is FAIL, not DONE.
//   - DONE/FAIL: all counters and captures frozen; only START leaves.
//   - STOP in IDLE/DONE/FAIL: ignored.
//   - CMP_CNT at all-ones: holds (no wrap); errors still count.
//   - Cycle counter at all-ones: holds.
// STRUCTURE
//   - Shared include comparador_defs.vh holds:
//       state encodings ST_IDLE/ST_RUN/ST_DONE/ST_FAIL;
//       default widths W, CW, EW.
//   - Sub-module sat_counter #(N): clear / increment-enable / saturate.
//     Instantiated for CMP_CNT, the RUN cycle counter and the skip counter.
//   - ERR_CNT lives inline in the FSM.
//   - One always block for the FSM; a registered compare stage.
// TESTING
//   1. RESET=0 two cycles, then 1.
//        -> STATE=0, CMP_CNT=0, ERR_CNT=0, Q_EQ=1, DONE=0.
//   2. START, then 10 cycles ENB=1 with QA=QB=4'hA, SA=SB=1, then STOP.
//        -> CMP_CNT=9 (SKIP=1), ERR_CNT=0, STATE=2, PASS=1.
//   3. START; at RUN cycle 5, QA=4'h3, QB=4'h7 for one cycle; STOP later.
//        -> ERR_CNT=1, STICKY=1, FIRST_CYC=5, FIRST_QA=3, FIRST_QB=7, PASS=0.
//   4. Continuous mismatch (SA=0, SB=1), MAX_ERR=4.
//        -> FAIL on the 4th counted sample, ERR_CNT=4, DONE=1.
//        -> Further STOP or mismatches change nothing.
//   5. ENB=0 for 6 RUN cycles with QA!=QB.
//        -> CMP_CNT and ERR_CNT unchanged; cycle counter advances 6.
//   6. Mid-run: START with STOP and a mismatch in the same cycle.
//        -> STATE=1, counters=0, STICKY=0.
//      Mid-run RESET=0.
//        -> STATE=0 on the next edge.

Source files
------------

// File: rtl/monitor_comparador_pkg.sv
// ============================================================================
// Module   : monitor_comparador_pkg
// Purpose  : Shared definitions for the comparator monitor: state encoding
//            and default widths of the compared data and of the counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package monitor_comparador_pkg;

    // Default widths: compared parallel data, comparison/cycle counters,
    // error counter.
    localparam int c_def_w  = 4;
    localparam int c_def_cw = 16;
    localparam int c_def_ew = 8;

    // Run-control states, encoded exactly as they appear on STATE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

endpackage : monitor_comparador_pkg

`default_nettype wire

// File: rtl/monitor_comparador_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with synchronous clear and increment enable that
//            holds at all-ones instead of wrapping.
// Ports    : clk    in  1  clock
//            rst    in  1  synchronous active-high reset
//            i_clr  in  1  clear to zero (wins over increment)
//            i_inc  in  1  increment by one unless already all-ones
//            o_cnt  out N  current count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [N-1:0] o_cnt
);

    logic [N-1:0] r_cnt_q;
    logic [N-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_inc && (r_cnt_q != {N{1'b1}})) begin
            w_cnt_d = r_cnt_q + N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_cnt = r_cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/monitor_comparador.sv
// ============================================================================
// Module   : monitor_comparador
// Purpose  : Sequential checker comparing two shift-register models (parallel
//            QA/QB and serial SA/SB) on every enabled cycle. Counts samples
//            and mismatches, captures the first failing cycle and data, and
//            ends a run in DONE (pass/fail by error count) or FAIL once the
//            error count reaches MAX_ERR.
// Ports    : CLK        in   1   clock, rising edge
//            RESET      in   1   synchronous active-low reset
//            START      in   1   start/restart a run (highest priority)
//            STOP       in   1   end the run normally
//            ENB        in   1   sample qualifier
//            QA, QB     in   W   parallel outputs under comparison
//            SA, SB     in   1   serial outputs under comparison
//            Q_EQ, S_EQ out  1   equality of the last counted sample
//            CMP_CNT    out  CW  counted comparisons (saturating)
//            ERR_CNT    out  EW  mismatching samples
//            FIRST_CYC  out  CW  run cycle of the first mismatch
//            FIRST_QA/QB out W   data captured at the first mismatch
//            STICKY     out  1   a mismatch has occurred this run
//            DONE, PASS out  1   run finished / finished with no errors
//            STATE      out  2   IDLE=0 RUN=1 DONE=2 FAIL=3
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module monitor_comparador
    import monitor_comparador_pkg::*;
#(
    parameter int W       = c_def_w,
    parameter int CW      = c_def_cw,
    parameter int EW      = c_def_ew,
    parameter int MAX_ERR = 4,
    parameter int SKIP    = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic          STOP,
    input  logic          ENB,
    input  logic [W-1:0]  QA,
    input  logic [W-1:0]  QB,
    input  logic          SA,
    input  logic          SB,
    output logic          Q_EQ,
    output logic          S_EQ,
    output logic [CW-1:0] CMP_CNT,
    output logic [EW-1:0] ERR_CNT,
    output logic [CW-1:0] FIRST_CYC,
    output logic [W-1:0]  FIRST_QA,
    output logic [W-1:0]  FIRST_QB,
    output logic          STICKY,
    output logic          DONE,
    output logic          PASS,
    output logic [1:0]    STATE
);

    // Skip counter only needs to reach SKIP; keep at least one bit so a
    // SKIP of zero still elaborates (it then reads as "already skipped").
    localparam int                   c_skip_w  = (SKIP < 1) ? 1 : $clog2(SKIP + 1);
    localparam logic [c_skip_w-1:0]  c_skip    = c_skip_w'(SKIP);
    localparam logic [EW-1:0]        c_max_err = EW'(MAX_ERR);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t        r_state_q,     w_state_d;
    logic [EW-1:0] r_err_q,       w_err_d;
    logic          r_q_eq_q,      w_q_eq_d;
    logic          r_s_eq_q,      w_s_eq_d;
    logic          r_sticky_q,    w_sticky_d;
    logic [CW-1:0] r_first_cyc_q, w_first_cyc_d;
    logic [W-1:0]  r_first_qa_q,  w_first_qa_d;
    logic [W-1:0]  r_first_qb_q,  w_first_qb_d;

    // ------------------------------------------------------------------
    // Sample qualification and comparison
    // ------------------------------------------------------------------
    logic                w_rst;
    logic                w_in_run;
    logic                w_skip_done;
    logic                w_sample;
    logic                w_q_ne;
    logic                w_s_ne;
    logic                w_mismatch;
    logic [CW-1:0]       w_cmp_cnt;
    logic [CW-1:0]       w_cyc_cnt;
    logic [c_skip_w-1:0] w_skip_cnt;

    assign w_rst       = ~RESET;
    assign w_in_run    = (r_state_q == ST_RUN);
    assign w_skip_done = (w_skip_cnt >= c_skip);

    // START pre-empts everything in its cycle, so the sample is dropped.
    assign w_sample    = w_in_run & ENB & w_skip_done & ~START;

    // Case inequality: an X or Z on either model is reported as a mismatch
    // rather than silently comparing equal.
    assign w_q_ne      = (QA !== QB);
    assign w_s_ne      = (SA !== SB);
    assign w_mismatch  = w_sample & (w_q_ne | w_s_ne);

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    sat_counter #(.N(CW)) u_cmp_cnt (
        .clk   (CLK),
        .rst   (w_rst),
        .i_clr (START),
        .i_inc (w_sample),
        .o_cnt (w_cmp_cnt)
    );

    // Cycles since RUN entry; ticks regardless of ENB.
    sat_counter #(.N(CW)) u_cyc_cnt (
        .clk   (CLK),
        .rst   (w_rst),
        .i_clr (START),
        .i_inc (w_in_run & ~START),
        .o_cnt (w_cyc_cnt)
    );

    // Enabled samples discarded while the register models fill.
    sat_counter #(.N(c_skip_w)) u_skip_cnt (
        .clk   (CLK),
        .rst   (w_rst),
        .i_clr (START),
        .i_inc (w_in_run & ENB & ~w_skip_done & ~START),
        .o_cnt (w_skip_cnt)
    );

    // ------------------------------------------------------------------
    // FSM, error counter, compare stage and first-failure capture
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_err_d       = r_err_q;
        w_q_eq_d      = r_q_eq_q;
        w_s_eq_d      = r_s_eq_q;
        w_sticky_d    = r_sticky_q;
        w_first_cyc_d = r_first_cyc_q;
        w_first_qa_d  = r_first_qa_q;
        w_first_qb_d  = r_first_qb_q;

        if (START) begin
            w_state_d     = ST_RUN;
            w_err_d       = '0;
            w_q_eq_d      = 1'b1;
            w_s_eq_d      = 1'b1;
            w_sticky_d    = 1'b0;
            w_first_cyc_d = '0;
            w_first_qa_d  = '0;
            w_first_qb_d  = '0;
        end else begin
            case (r_state_q)
                ST_RUN: begin
                    if (w_sample) begin
                        w_q_eq_d = ~w_q_ne;
                        w_s_eq_d = ~w_s_ne;
                    end
                    if (w_mismatch) begin
                        if (r_err_q != {EW{1'b1}}) begin
                            w_err_d = r_err_q + EW'(1);
                        end
                        if (!r_sticky_q) begin
                            w_sticky_d    = 1'b1;
                            w_first_cyc_d = w_cyc_cnt;
                            w_first_qa_d  = QA;
                            w_first_qb_d  = QB;
                        end
                    end
                    // The sample is accounted for before STOP is honoured,
                    // so hitting the limit on the STOP cycle still fails.
                    if (w_mismatch && (w_err_d >= c_max_err)) begin
                        w_state_d = ST_FAIL;
                    end else if (STOP) begin
                        w_state_d = ST_DONE;
                    end
                end
                default: begin
                    // IDLE, DONE and FAIL hold everything until START.
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state_q     <= ST_IDLE;
            r_err_q       <= '0;
            r_q_eq_q      <= 1'b1;
            r_s_eq_q      <= 1'b1;
            r_sticky_q    <= 1'b0;
            r_first_cyc_q <= '0;
            r_first_qa_q  <= '0;
            r_first_qb_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_err_q       <= w_err_d;
            r_q_eq_q      <= w_q_eq_d;
            r_s_eq_q      <= w_s_eq_d;
            r_sticky_q    <= w_sticky_d;
            r_first_cyc_q <= w_first_cyc_d;
            r_first_qa_q  <= w_first_qa_d;
            r_first_qb_q  <= w_first_qb_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Q_EQ      = r_q_eq_q;
    assign S_EQ      = r_s_eq_q;
    assign CMP_CNT   = w_cmp_cnt;
    assign ERR_CNT   = r_err_q;
    assign FIRST_CYC = r_first_cyc_q;
    assign FIRST_QA  = r_first_qa_q;
    assign FIRST_QB  = r_first_qb_q;
    assign STICKY    = r_sticky_q;
    assign DONE      = (r_state_q == ST_DONE) || (r_state_q == ST_FAIL);
    assign PASS      = DONE && (r_err_q == '0);
    assign STATE     = r_state_q;

endmodule : monitor_comparador

`default_nettype wire

// File: tb/tb_monitor_comparador.sv
// ============================================================================
// Module   : tb_monitor_comparador
// Purpose  : Self-checking bench for monitor_comparador (default parameters:
//            W=4, CW=16, EW=8, MAX_ERR=4, SKIP=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_monitor_comparador;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic        STOP;
    logic        ENB;
    logic [3:0]  QA;
    logic [3:0]  QB;
    logic        SA;
    logic        SB;
    logic        Q_EQ;
    logic        S_EQ;
    logic [15:0] CMP_CNT;
    logic [7:0]  ERR_CNT;
    logic [15:0] FIRST_CYC;
    logic [3:0]  FIRST_QA;
    logic [3:0]  FIRST_QB;
    logic        STICKY;
    logic        DONE;
    logic        PASS;
    logic [1:0]  STATE;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    monitor_comparador dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .STOP      (STOP),
        .ENB       (ENB),
        .QA        (QA),
        .QB        (QB),
        .SA        (SA),
        .SB        (SB),
        .Q_EQ      (Q_EQ),
        .S_EQ      (S_EQ),
        .CMP_CNT   (CMP_CNT),
        .ERR_CNT   (ERR_CNT),
        .FIRST_CYC (FIRST_CYC),
        .FIRST_QA  (FIRST_QA),
        .FIRST_QB  (FIRST_QB),
        .STICKY    (STICKY),
        .DONE      (DONE),
        .PASS      (PASS),
        .STATE     (STATE)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic       enb;
        logic [3:0] qa;
        logic [3:0] qb;
        logic       sa;
        logic       sb;
        logic [1:0] e_state;
        int         e_cmp;
        int         e_err;
        logic       e_qeq;
        logic       e_seq;
        logic       e_sticky;
        int         e_fcyc;
        logic [3:0] e_fqa;
        logic [3:0] e_fqb;
        logic       e_done;
        logic       e_pass;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge.
    task automatic step(input logic st, input logic sp, input logic en,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic s_a, input logic s_b);
        START = st; STOP = sp; ENB = en;
        QA = a; QB = b; SA = s_a; SB = s_b;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b0; START = 1'b0; STOP = 1'b0; ENB = 1'b0;
        QA = 4'h0; QB = 4'h0; SA = 1'b0; SB = 1'b0;

        // ---------------- Reset ----------------
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b1;
        chk("rst.state",  32'(STATE),   32'd0);
        chk("rst.cmp",    32'(CMP_CNT), 32'd0);
        chk("rst.err",    32'(ERR_CNT), 32'd0);
        chk("rst.qeq",    32'(Q_EQ),    32'd1);
        chk("rst.seq",    32'(S_EQ),    32'd1);
        chk("rst.done",   32'(DONE),    32'd0);
        chk("rst.pass",   32'(PASS),    32'd0);
        chk("rst.sticky", 32'(STICKY),  32'd0);
        // STOP in IDLE is ignored.
        step(0, 1, 1, 4'h1, 4'h2, 0, 1);
        chk("idle_stop.state", 32'(STATE),   32'd0);
        chk("idle_stop.err",   32'(ERR_CNT), 32'd0);

        // ---------------- Table-driven run ----------------
        //        st sp en qa    qb    sa sb | state cmp err qeq seq stk fcyc fqa fqb done pass
        tbl[0] = '{1, 0, 1, 4'hA, 4'hA, 1, 1,  2'd1, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0}; // START
        tbl[1] = '{0, 0, 1, 4'hA, 4'hA, 1, 1,  2'd1, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0}; // skipped, cyc0
        tbl[2] = '{0, 0, 1, 4'hA, 4'hA, 1, 1,  2'd1, 1, 0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0}; // cyc1
        tbl[3] = '{0, 0, 0, 4'h3, 4'h7, 1, 1,  2'd1, 1, 0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0}; // disabled, cyc2
        tbl[4] = '{0, 0, 1, 4'h3, 4'h7, 1, 1,  2'd1, 2, 1, 0, 1, 1, 3, 4'h3, 4'h7, 0, 0}; // first mismatch cyc3
        tbl[5] = '{0, 0, 1, 4'h5, 4'h5, 0, 1,  2'd1, 3, 2, 1, 0, 1, 3, 4'h3, 4'h7, 0, 0}; // serial only
        tbl[6] = '{0, 1, 1, 4'h1, 4'h2, 0, 1,  2'd2, 4, 3, 0, 0, 1, 3, 4'h3, 4'h7, 1, 0}; // both + STOP
        tbl[7] = '{0, 1, 1, 4'h1, 4'h2, 0, 1,  2'd2, 4, 3, 0, 0, 1, 3, 4'h3, 4'h7, 1, 0}; // frozen in DONE
        tbl[8] = '{1, 1, 1, 4'h1, 4'h2, 0, 1,  2'd1, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0}; // START+STOP+mm

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].start, tbl[i].stop, tbl[i].enb, tbl[i].qa, tbl[i].qb, tbl[i].sa, tbl[i].sb);
            chk($sformatf("v%0d.state",  i), 32'(STATE),     32'(tbl[i].e_state));
            chk($sformatf("v%0d.cmp",    i), 32'(CMP_CNT),   32'(tbl[i].e_cmp));
            chk($sformatf("v%0d.err",    i), 32'(ERR_CNT),   32'(tbl[i].e_err));
            chk($sformatf("v%0d.qeq",    i), 32'(Q_EQ),      32'(tbl[i].e_qeq));
            chk($sformatf("v%0d.seq",    i), 32'(S_EQ),      32'(tbl[i].e_seq));
            chk($sformatf("v%0d.sticky", i), 32'(STICKY),    32'(tbl[i].e_sticky));
            chk($sformatf("v%0d.fcyc",   i), 32'(FIRST_CYC), 32'(tbl[i].e_fcyc));
            chk($sformatf("v%0d.fqa",    i), 32'(FIRST_QA),  32'(tbl[i].e_fqa));
            chk($sformatf("v%0d.fqb",    i), 32'(FIRST_QB),  32'(tbl[i].e_fqb));
            chk($sformatf("v%0d.done",   i), 32'(DONE),      32'(tbl[i].e_done));
            chk($sformatf("v%0d.pass",   i), 32'(PASS),      32'(tbl[i].e_pass));
        end

        // ---------------- Clean run: 10 enabled cycles, then STOP ----------------
        step(1, 0, 1, 4'hA, 4'hA, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 4'hA, 4'hA, 1, 1);
        step(0, 1, 0, 4'hA, 4'hA, 1, 1);
        chk("clean.cmp",   32'(CMP_CNT), 32'd9);
        chk("clean.err",   32'(ERR_CNT), 32'd0);
        chk("clean.state", 32'(STATE),   32'd2);
        chk("clean.pass",  32'(PASS),    32'd1);
        chk("clean.done",  32'(DONE),    32'd1);

        // ---------------- Single mismatch at RUN cycle 5 ----------------
        step(1, 0, 1, 4'hA, 4'hA, 1, 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) step(0, 0, 1, 4'h3, 4'h7, 1, 1);
            else        step(0, 0, 1, 4'hA, 4'hA, 1, 1);
        end
        step(0, 1, 0, 4'hA, 4'hA, 1, 1);
        chk("one.err",    32'(ERR_CNT),   32'd1);
        chk("one.cmp",    32'(CMP_CNT),   32'd7);
        chk("one.sticky", 32'(STICKY),    32'd1);
        chk("one.fcyc",   32'(FIRST_CYC), 32'd5);
        chk("one.fqa",    32'(FIRST_QA),  32'h3);
        chk("one.fqb",    32'(FIRST_QB),  32'h7);
        chk("one.pass",   32'(PASS),      32'd0);
        chk("one.state",  32'(STATE),     32'd2);

        // ---------------- Continuous serial mismatch -> FAIL (with STOP on the 4th) ----------------
        step(1, 0, 1, 4'h5, 4'h5, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, (i == 4), 1, 4'h5, 4'h5, 0, 1);
            if (i == 3) begin
                chk("fail.pre_state", 32'(STATE),   32'd1);
                chk("fail.pre_err",   32'(ERR_CNT), 32'd3);
            end
        end
        chk("fail.state", 32'(STATE),   32'd3);
        chk("fail.err",   32'(ERR_CNT), 32'd4);
        chk("fail.cmp",   32'(CMP_CNT), 32'd4);
        chk("fail.done",  32'(DONE),    32'd1);
        chk("fail.pass",  32'(PASS),    32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 4'h1, 4'h2, 0, 1);
        chk("fail_hold.state", 32'(STATE),     32'd3);
        chk("fail_hold.err",   32'(ERR_CNT),   32'd4);
        chk("fail_hold.cmp",   32'(CMP_CNT),   32'd4);
        chk("fail_hold.fcyc",  32'(FIRST_CYC), 32'd1);

        // ---------------- ENB low for 6 RUN cycles ----------------
        step(1, 0, 1, 4'hA, 4'hA, 1, 1);
        step(0, 0, 1, 4'hA, 4'hA, 1, 1);          // cyc0, skipped
        step(0, 0, 1, 4'hA, 4'hA, 1, 1);          // cyc1, counted
        for (int i = 0; i < 6; i++) step(0, 0, 0, 4'h1, 4'h2, 0, 1);  // cyc2..7
        chk("enb0.cmp", 32'(CMP_CNT), 32'd1);
        chk("enb0.err", 32'(ERR_CNT), 32'd0);
        step(0, 0, 1, 4'h6, 4'h9, 1, 1);          // cyc8, mismatch
        chk("enb0.fcyc", 32'(FIRST_CYC), 32'd8);
        chk("enb0.cmp2", 32'(CMP_CNT),   32'd2);
        chk("enb0.err2", 32'(ERR_CNT),   32'd1);

        // ---------------- Unknown on QB counts as a mismatch ----------------
        step(1, 0, 1, 4'hA, 4'hA, 1, 1);
        step(0, 0, 1, 4'hA, 4'hA, 1, 1);
        step(0, 0, 1, 4'hA, 4'bxxxx, 1, 1);
        chk("x.err", 32'(ERR_CNT), 32'd1);
        chk("x.qeq", 32'(Q_EQ),    32'd0);
        chk("x.seq", 32'(S_EQ),    32'd1);
        step(0, 0, 1, 4'h3, 4'h3, 1, 1);
        chk("x.cmp", 32'(CMP_CNT), 32'd2);

        // ---------------- Mid-run reset ----------------
        RESET = 1'b0;
        step(0, 0, 1, 4'h1, 4'h2, 0, 1);
        chk("mrst.state",  32'(STATE),    32'd0);
        chk("mrst.cmp",    32'(CMP_CNT),  32'd0);
        chk("mrst.err",    32'(ERR_CNT),  32'd0);
        chk("mrst.qeq",    32'(Q_EQ),     32'd1);
        chk("mrst.sticky", 32'(STICKY),   32'd0);
        chk("mrst.fqb",    32'(FIRST_QB), 32'd0);
        RESET = 1'b1;
        step(0, 0, 0, 4'h0, 4'h0, 0, 0);
        chk("mrst.idle", 32'(STATE), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_monitor_comparador

`default_nettype wire
